// File: rtl/axi_fifo_pkg.sv
// Shared constants and helpers for the AXI channel FIFOs.
// No logic; compile-time values only.
// Not applicable (no handshakes).
package axi_fifo_pkg;

    // Payload widths of the five AXI channels
    localparam int AR_W = 49;
    localparam int AW_W = 49;
    localparam int W_W  = 37;
    localparam int R_W  = 39;
    localparam int B_W  = 3;

    // Address bits needed to index a DEPTH-entry array (at least 1)
    function automatic int ptr_w(input int depth);
        return (depth <= 1) ? 1 : $clog2(depth);
    endfunction

endpackage

// File: rtl/axi_fifo_mem.sv
// DEPTH x WIDTH register array with one write port and an async read port.
// Write takes effect on the next clk edge; read is combinational.
// No flow control; the caller owns we gating.
module axi_fifo_mem
    import axi_fifo_pkg::*;
#(
    parameter int WIDTH = AR_W,
    parameter int DEPTH = 4,
    parameter int AW    = ptr_w(DEPTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    // Storage: cleared on reset, one entry written per accepted push
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/axi_chan_sync_fifo.sv
// Single-clock valid/ready FIFO for one AXI channel, optional empty bypass.
// Write-to-read 1 cycle (0 cycles through the bypass when BYPASS=1 and empty).
// ready_o = not full; a full FIFO does not write through on a same-cycle pop.
module axi_chan_sync_fifo
    import axi_fifo_pkg::*;
#(
    parameter int WIDTH     = AR_W,
    parameter int DEPTH     = 4,
    parameter int BYPASS    = 0,
    parameter int AF_THRESH = DEPTH - 1
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       flush,
    input  logic [WIDTH-1:0]           wdata,
    input  logic                       valid_i,
    output logic                       ready_o,
    output logic [WIDTH-1:0]           rdata,
    output logic                       valid_o,
    input  logic                       ready_i,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       almost_full,
    output logic                       ovf_err,
    output logic                       udf_err
);

    localparam int             PTR_W   = ptr_w(DEPTH);
    localparam int             CNT_W   = PTR_W + 1;
    localparam bit             BYP_EN  = (BYPASS != 0);
    localparam logic [PTR_W:0] PTR_ONE = {{PTR_W{1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_ONE = {{PTR_W{1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] AF_LVL  = CNT_W'(AF_THRESH);

    // Pointers carry one extra wrap bit to tell full from empty
    logic [PTR_W:0]     wptr;
    logic [PTR_W:0]     rptr;
    logic [CNT_W-1:0]   count_q;
    logic [CNT_W-1:0]   count_nxt;
    logic [WIDTH-1:0]   mem_rdata;
    logic               empty;
    logic               full;
    logic               byp_sel;
    logic               byp_thru;
    logic               push;
    logic               pop;
    logic               udf_set;

    assign empty = (wptr == rptr);
    assign full  = (wptr[PTR_W-1:0] == rptr[PTR_W-1:0]) && (wptr[PTR_W] != rptr[PTR_W]);

    // Bypass only presents the incoming beat while nothing is queued ahead of it
    assign byp_sel  = BYP_EN && empty && valid_i;
    assign byp_thru = byp_sel && ready_i;

    assign ready_o = ~full;
    assign valid_o = empty ? byp_sel : 1'b1;
    assign rdata   = byp_sel ? wdata : mem_rdata;

    // A beat that passes straight through is never stored
    assign push    = valid_i && ready_o && !byp_thru;
    assign pop     = !empty && ready_i;
    assign udf_set = !BYP_EN && ready_i && !valid_o;

    assign count = count_q;

    axi_fifo_mem #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH),
        .AW    (PTR_W)
    ) u_mem (
        .clk   (clk),
        .rst_n (rst_n),
        .we    (push && !flush),
        .waddr (wptr[PTR_W-1:0]),
        .wdata (wdata),
        .raddr (rptr[PTR_W-1:0]),
        .rdata (mem_rdata)
    );

    // Occupancy after this cycle's push/pop
    always_comb begin
        count_nxt = count_q;
        if (push && !pop) begin
            count_nxt = count_q + CNT_ONE;
        end else if (pop && !push) begin
            count_nxt = count_q - CNT_ONE;
        end
    end

    // Pointers, count, almost_full and sticky error flags; flush beats push/pop
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr        <= '0;
            rptr        <= '0;
            count_q     <= '0;
            almost_full <= 1'b0;
            ovf_err     <= 1'b0;
            udf_err     <= 1'b0;
        end else if (flush) begin
            wptr        <= '0;
            rptr        <= '0;
            count_q     <= '0;
            almost_full <= 1'b0;
            ovf_err     <= 1'b0;
            udf_err     <= 1'b0;
        end else begin
            if (push) begin
                wptr <= wptr + PTR_ONE;
            end
            if (pop) begin
                rptr <= rptr + PTR_ONE;
            end
            count_q     <= count_nxt;
            almost_full <= (count_nxt >= AF_LVL);
            ovf_err     <= ovf_err | (valid_i & full);
            udf_err     <= udf_err | udf_set;
        end
    end

endmodule

// File: tb/tb_axi_chan_sync_fifo.sv
// Scoreboard bench for axi_chan_sync_fifo: one plain instance, one with bypass.
// Inputs change 1 time unit after posedge; outputs compared on negedge.
// Backpressure is driven directly through ready_i patterns and random phases.
module tb_axi_chan_sync_fifo;
    import axi_fifo_pkg::*;

    localparam int W  = AR_W;
    localparam int D  = 4;
    localparam int BW = 8;
    localparam int AF = D - 1;

    logic            clk;
    logic            rst_n;

    // plain instance (BYPASS=0)
    logic            flush;
    logic [W-1:0]    wdata;
    logic            valid_i;
    logic            ready_o;
    logic [W-1:0]    rdata;
    logic            valid_o;
    logic            ready_i;
    logic [2:0]      count;
    logic            almost_full;
    logic            ovf_err;
    logic            udf_err;

    // bypass instance (BYPASS=1)
    logic            b_flush;
    logic [BW-1:0]   b_wdata;
    logic            b_valid_i;
    logic            b_ready_o;
    logic [BW-1:0]   b_rdata;
    logic            b_valid_o;
    logic            b_ready_i;
    logic [2:0]      b_count;
    logic            b_almost_full;
    logic            b_ovf_err;
    logic            b_udf_err;

    int n_total = 0;
    int n_bad   = 0;

    // scoreboards and reference flags
    logic [W-1:0]  q[$];
    logic [BW-1:0] bq[$];
    logic          m_ovf, m_udf, mb_ovf;

    axi_chan_sync_fifo #(.WIDTH(W), .DEPTH(D), .BYPASS(0), .AF_THRESH(AF)) u_dut (
        .clk(clk), .rst_n(rst_n), .flush(flush), .wdata(wdata), .valid_i(valid_i),
        .ready_o(ready_o), .rdata(rdata), .valid_o(valid_o), .ready_i(ready_i),
        .count(count), .almost_full(almost_full), .ovf_err(ovf_err), .udf_err(udf_err)
    );

    axi_chan_sync_fifo #(.WIDTH(BW), .DEPTH(D), .BYPASS(1), .AF_THRESH(AF)) u_byp (
        .clk(clk), .rst_n(rst_n), .flush(b_flush), .wdata(b_wdata), .valid_i(b_valid_i),
        .ready_o(b_ready_o), .rdata(b_rdata), .valid_o(b_valid_o), .ready_i(b_ready_i),
        .count(b_count), .almost_full(b_almost_full), .ovf_err(b_ovf_err), .udf_err(b_udf_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    // Compare both instances against the scoreboards, then advance the model
    task automatic cycle();
        bit m_empty, m_full, b_empty, b_full;
        @(negedge clk);
        m_empty = (q.size() == 0);
        m_full  = (q.size() == D);
        b_empty = (bq.size() == 0);
        b_full  = (bq.size() == D);

        check("cnt",   count,       q.size());
        check("vld",   valid_o,     !m_empty);
        check("rdy",   ready_o,     !m_full);
        check("af",    almost_full, q.size() >= AF);
        check("ovf",   ovf_err,     m_ovf);
        check("udf",   udf_err,     m_udf);
        if (!m_empty) check("rdata", rdata, q[0]);

        check("b_cnt", b_count,       bq.size());
        check("b_vld", b_valid_o,     !b_empty || b_valid_i);
        check("b_rdy", b_ready_o,     !b_full);
        check("b_af",  b_almost_full, bq.size() >= AF);
        check("b_ovf", b_ovf_err,     mb_ovf);
        check("b_udf", b_udf_err,     1'b0);
        if (!b_empty)       check("b_rdata", b_rdata, bq[0]);
        else if (b_valid_i) check("b_thru",  b_rdata, b_wdata);

        if (rst_n) begin
            if (flush) begin
                q.delete(); m_ovf = 0; m_udf = 0;
            end else begin
                m_ovf = m_ovf | (valid_i && m_full);
                m_udf = m_udf | (ready_i && m_empty);
                if (!m_empty && ready_i) void'(q.pop_front());
                if (valid_i && !m_full)  q.push_back(wdata);
            end
            if (b_flush) begin
                bq.delete(); mb_ovf = 0;
            end else begin
                mb_ovf = mb_ovf | (b_valid_i && b_full);
                if (!(b_empty && b_valid_i && b_ready_i)) begin
                    if (!b_empty && b_ready_i) void'(bq.pop_front());
                    if (b_valid_i && !b_full)  bq.push_back(b_wdata);
                end
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic reset_checks(input string tag);
        check({tag, "_rdy"},   ready_o,     1'b1);
        check({tag, "_vld"},   valid_o,     1'b0);
        check({tag, "_rdata"}, rdata,       '0);
        check({tag, "_cnt"},   count,       '0);
        check({tag, "_af"},    almost_full, 1'b0);
        check({tag, "_ovf"},   ovf_err,     1'b0);
        check({tag, "_udf"},   udf_err,     1'b0);
        check({tag, "_brdy"},  b_ready_o,   1'b1);
        check({tag, "_bvld"},  b_valid_o,   1'b0);
        check({tag, "_bcnt"},  b_count,     '0);
    endtask

    initial begin
        rst_n = 0; flush = 0; wdata = '0; valid_i = 0; ready_i = 0;
        b_flush = 0; b_wdata = '0; b_valid_i = 0; b_ready_i = 0;
        m_ovf = 0; m_udf = 0; mb_ovf = 0;
        repeat (2) cycle();
        rst_n = 1;
        reset_checks("reset");
        cycle();

        // fill to full with the read side stalled, then drain in order
        ready_i = 0; valid_i = 1;
        for (int i = 0; i < D; i++) begin
            wdata = W'(32'hA + i);
            cycle();
            check("fill_cnt", count, i + 1);
        end
        valid_i = 0;
        check("fill_full_rdy", ready_o, 1'b0);
        check("fill_af", almost_full, 1'b1);
        ready_i = 1;
        repeat (D) cycle();
        check("drain_vld", valid_o, 1'b0);
        cycle();
        ready_i = 0;
        check("udf_set", udf_err, 1'b1);
        flush = 1; cycle(); flush = 0;
        check("udf_flush", udf_err, 1'b0);

        // two in flight, push and pop every cycle across pointer wrap
        valid_i = 1; wdata = W'(1); cycle();
        wdata = W'(2); cycle();
        ready_i = 1;
        for (int v = 3; v <= 10; v++) begin
            wdata = W'(v);
            cycle();
            check("wrap_cnt", count, 2);
        end
        valid_i = 0;
        repeat (2) cycle();
        ready_i = 0;

        // full with push and pop together: pop wins, push blocked, ovf sticks
        valid_i = 1;
        for (int i = 0; i < D; i++) begin
            wdata = W'(32'h21 + i);
            cycle();
        end
        ready_i = 1; wdata = W'(32'h25);
        cycle();
        valid_i = 0; ready_i = 0;
        check("fullsim_rdy", ready_o, 1'b1);
        check("fullsim_cnt", count, 3);
        check("fullsim_ovf", ovf_err, 1'b1);
        repeat (2) cycle();
        check("ovf_hold", ovf_err, 1'b1);
        flush = 1; cycle(); flush = 0;
        check("flush_cnt", count, 0);
        check("flush_vld", valid_o, 1'b0);
        check("flush_ovf", ovf_err, 1'b0);

        // bypass: pass-through when empty, store when stalled
        b_valid_i = 1; b_wdata = 8'h55; b_ready_i = 1;
        #1;
        check("byp_vld_now", b_valid_o, 1'b1);
        check("byp_rdata_now", b_rdata, 8'h55);
        cycle();
        check("byp_cnt0", b_count, 0);
        b_ready_i = 0;
        cycle();
        b_valid_i = 0;
        check("byp_store_cnt", b_count, 1);
        check("byp_store_vld", b_valid_o, 1'b1);
        check("byp_store_rdata", b_rdata, 8'h55);
        b_ready_i = 1; cycle(); b_ready_i = 0;
        b_valid_i = 1;
        for (int i = 0; i < D + 1; i++) begin
            b_wdata = BW'(8'h60 + i);
            cycle();
        end
        b_valid_i = 0;
        check("byp_ovf", b_ovf_err, 1'b1);

        // asynchronous reset between edges with data in flight
        valid_i = 1; wdata = W'(32'h77); cycle();
        wdata = W'(32'h78); cycle();
        valid_i = 0;
        #2 rst_n = 0;
        #1;
        q.delete(); bq.delete(); m_ovf = 0; m_udf = 0; mb_ovf = 0;
        reset_checks("arst");
        cycle();
        rst_n = 1;
        valid_i = 1; wdata = W'(32'h99);
        cycle();
        valid_i = 0;
        check("post_rst_cnt", count, 1);
        ready_i = 1; cycle(); ready_i = 0;

        // random traffic on both instances
        for (int n = 0; n < 400; n++) begin
            valid_i   = 1'($urandom_range(0, 1));
            ready_i   = 1'($urandom_range(0, 1));
            flush     = ($urandom_range(0, 24) == 0);
            wdata     = W'({$urandom(), $urandom()});
            b_valid_i = 1'($urandom_range(0, 1));
            b_ready_i = 1'($urandom_range(0, 1));
            b_flush   = ($urandom_range(0, 24) == 0);
            b_wdata   = BW'($urandom());
            cycle();
        end
        valid_i = 0; ready_i = 0; flush = 0;
        b_valid_i = 0; b_ready_i = 0; b_flush = 0;
        cycle();

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
